// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART buffer-path FIFO: read-mode selectors,
// circular pointer advance and occupancy-counter sizing.
package uart_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART FIFO: one synchronous write port and one
// asynchronous read port.
module uart_fifo_mem #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [PTR_W-1:0]     waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [PTR_W-1:0]     raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO between the UART datapaths and host logic,
// with simultaneous push/pop, occupancy thresholds and sticky error flags.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_BITS           = 8,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter int FWFT                = FIFO_MODE_STD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clear_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  if (DEPTH < 2 || ALMOST_EMPTY_THRESH < 0 ||
      ALMOST_EMPTY_THRESH >= ALMOST_FULL_THRESH ||
      ALMOST_FULL_THRESH > DEPTH) begin : g_param_check
    $error("uart_sync_fifo: DEPTH must be >= 2 and 0 <= AE < AF <= DEPTH");
  end

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 push_ok, pop_ok;
  logic [DATA_BITS-1:0] head_data;

  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(ALMOST_FULL_THRESH));
  assign almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  always_comb begin
    pop_ok      = rd_en & ~empty;
    push_ok     = wr_en & (~full | pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok) begin
      wr_ptr_d = PTR_W'(ptr_next(int'(wr_ptr_q), DEPTH));
    end
    if (pop_ok) begin
      rd_ptr_d = PTR_W'(ptr_next(int'(rd_ptr_q), DEPTH));
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full && !pop_ok) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // A push landing in the reset cycle must not disturb storage either.
  uart_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_ok & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rd_data  = head_data;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 rd_valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_ok;
        if (pop_ok) begin
          rd_data_q <= head_data;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
